// File: rtl/cache_control_pkg.sv
// Shared types for the L1 cache controller: address/data mux selects, FSM states
// and LRU geometry.
package sourcemux;
  typedef enum logic {
    memory = 1'b0,
    cache  = 1'b1
  } sourcemux_sel_t;
endpackage

package datainmux;
  typedef enum logic {
    cpu  = 1'b0,
    pmem = 1'b1
  } datainmux_sel_t;
endpackage

package cache_control_pkg;
  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  localparam int LRU_SETS  = 8;
  localparam int LRU_IDX_W = $clog2(LRU_SETS);
endpackage

// File: rtl/cache_control_lru.sv
// Per-set 1-bit LRU storage: combinational read, edge write, synchronous clear.
module lru_array
  import cache_control_pkg::*;
#(
  parameter int NUM_SETS = LRU_SETS,
  parameter int IDX_W    = LRU_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_bit,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_bit
);

  logic [NUM_SETS-1:0] bits_q;

  assign rd_bit = bits_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst)     bits_q <= '0;
    else if (we) bits_q[wr_idx] <= wr_bit;
  end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way L1 cache: hit / clean miss / dirty miss handling,
// datapath load enables and per-set LRU ownership.
module cache_control
  import cache_control_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [2:0]                index,
  input  logic [1:0]                hit,
  input  logic [1:0]                valid,
  input  logic [1:0]                dirty,
  input  logic                      pmem_resp,
  output logic                      mem_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output sourcemux::sourcemux_sel_t sourcemux_sel,
  output logic                      way_sel,
  output datainmux::datainmux_sel_t datainmux_sel,
  output logic [1:0]                load_data,
  output logic [1:0]                load_tag,
  output logic [1:0]                set_valid,
  output logic [1:0]                set_dirty,
  output logic [1:0]                clear_dirty
);

  if (NUM_WAYS != 2) begin : g_ways_chk
    $error("cache_control: only NUM_WAYS == 2 is supported");
  end
  if (NUM_SETS != (1 << $bits(index))) begin : g_sets_chk
    $error("cache_control: NUM_SETS must equal 2^index width");
  end

  cache_state_t state_q, state_d;
  logic         victim_q, victim_d;
  logic         lru_rd, lru_we, lru_wd;
  logic         req, hit_way, any_hit;

  assign req     = mem_read | mem_write;
  assign any_hit = |hit;
  // Both ways matching is illegal; resolve toward way 0.
  assign hit_way = ~hit[0];

  lru_array #(.NUM_SETS(NUM_SETS), .IDX_W($bits(index))) u_lru (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (index),
    .rd_bit (lru_rd),
    .we     (lru_we),
    .wr_idx (index),
    .wr_bit (lru_wd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    sourcemux_sel = sourcemux::memory;
    way_sel       = 1'b0;
    datainmux_sel = datainmux::cpu;
    load_data     = '0;
    load_tag      = '0;
    set_valid     = '0;
    set_dirty     = '0;
    clear_dirty   = '0;
    lru_we        = 1'b0;
    lru_wd        = 1'b0;

    unique case (state_q)
      CHECK: begin
        if (req && any_hit) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          lru_we   = 1'b1;
          lru_wd   = ~hit_way;
          if (mem_write) begin
            load_data[hit_way] = 1'b1;
            set_dirty[hit_way] = 1'b1;
          end
        end else if (req) begin
          victim_d = lru_rd;
          state_d  = (valid[lru_rd] && dirty[lru_rd]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        sourcemux_sel = sourcemux::cache;
        way_sel       = victim_q;
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read     = 1'b1;
        way_sel       = victim_q;
        datainmux_sel = datainmux::pmem;
        if (pmem_resp) begin
          load_data[victim_q]   = 1'b1;
          load_tag[victim_q]    = 1'b1;
          set_valid[victim_q]   = 1'b1;
          clear_dirty[victim_q] = 1'b1;
          state_d               = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hits, clean/dirty misses, reset mid-fill.
module tb_cache_control;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      mem_read, mem_write, pmem_resp;
  logic [2:0]                index;
  logic [1:0]                hit, valid, dirty;
  logic                      mem_resp, pmem_read, pmem_write, way_sel;
  sourcemux::sourcemux_sel_t sourcemux_sel;
  datainmux::datainmux_sel_t datainmux_sel;
  logic [1:0]                load_data, load_tag, set_valid, set_dirty, clear_dirty;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .index         (index),
    .hit           (hit),
    .valid         (valid),
    .dirty         (dirty),
    .pmem_resp     (pmem_resp),
    .mem_resp      (mem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .sourcemux_sel (sourcemux_sel),
    .way_sel       (way_sel),
    .datainmux_sel (datainmux_sel),
    .load_data     (load_data),
    .load_tag      (load_tag),
    .set_valid     (set_valid),
    .set_dirty     (set_dirty),
    .clear_dirty   (clear_dirty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] idx,
                       input logic [1:0] h, input logic [1:0] v, input logic [1:0] d,
                       input logic pr);
    mem_read = rd; mem_write = wr; index = idx;
    hit = h; valid = v; dirty = d; pmem_resp = pr;
  endtask

  // Read and write to pmem are mutually exclusive at all times.
  always @(negedge clk) if (rst === 1'b0) chk("pmem_excl", 32'(pmem_read & pmem_write), 0);

  initial begin
    rst = 1'b1;
    drive(0, 0, 3'd0, 2'b00, 2'b00, 2'b00, 0);
    tick(); tick();
    rst = 1'b0;

    // Reset / idle state
    @(negedge clk);
    chk("rst_resp",  32'(mem_resp), 0);
    chk("rst_prd",   32'(pmem_read), 0);
    chk("rst_pwr",   32'(pmem_write), 0);
    chk("rst_src",   32'(sourcemux_sel), 32'(sourcemux::memory));
    chk("rst_way",   32'(way_sel), 0);
    chk("rst_din",   32'(datainmux_sel), 32'(datainmux::cpu));
    chk("rst_ld",    32'(load_data), 0);
    chk("rst_lru",   32'(dut.u_lru.bits_q), 0);

    // Read hit way 0, index 2
    tick(); drive(1, 0, 3'd2, 2'b01, 2'b11, 2'b00, 0);
    @(negedge clk);
    chk("rh_resp", 32'(mem_resp), 1);
    chk("rh_way",  32'(way_sel), 0);
    chk("rh_ld",   32'(load_data), 0);
    chk("rh_prd",  32'(pmem_read), 0);
    tick(); drive(0, 0, 3'd2, 2'b00, 2'b11, 2'b00, 0);
    chk("rh_lru2", 32'(dut.u_lru.bits_q[2]), 1);

    // Write hit way 1, index 2
    drive(0, 1, 3'd2, 2'b10, 2'b11, 2'b00, 0);
    @(negedge clk);
    chk("wh_resp", 32'(mem_resp), 1);
    chk("wh_way",  32'(way_sel), 1);
    chk("wh_ld",   32'(load_data), 32'b10);
    chk("wh_sd",   32'(set_dirty), 32'b10);
    chk("wh_din",  32'(datainmux_sel), 32'(datainmux::cpu));
    tick(); drive(0, 0, 3'd2, 2'b00, 2'b11, 2'b00, 0);
    chk("wh_lru2", 32'(dut.u_lru.bits_q[2]), 0);

    // Clean miss, index 5 (lru[5]=0 -> victim way 0), pmem_resp on 4th ALLOCATE cycle
    drive(1, 0, 3'd5, 2'b00, 2'b00, 2'b00, 0);
    @(negedge clk);
    chk("cm_resp0", 32'(mem_resp), 0);
    chk("cm_prd0",  32'(pmem_read), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("cm_prd",  32'(pmem_read), 1);
      chk("cm_src",  32'(sourcemux_sel), 32'(sourcemux::memory));
      chk("cm_din",  32'(datainmux_sel), 32'(datainmux::pmem));
      chk("cm_tag0", 32'(load_tag), 0);
    end
    tick(); pmem_resp = 1'b1;
    @(negedge clk);
    chk("cm_ftag", 32'(load_tag), 32'b01);
    chk("cm_fval", 32'(set_valid), 32'b01);
    chk("cm_fld",  32'(load_data), 32'b01);
    chk("cm_fcd",  32'(clear_dirty), 32'b01);
    chk("cm_fresp", 32'(mem_resp), 0);
    tick(); drive(1, 0, 3'd5, 2'b01, 2'b01, 2'b00, 0);
    @(negedge clk);
    chk("cm_hresp", 32'(mem_resp), 1);
    chk("cm_hprd",  32'(pmem_read), 0);
    tick(); drive(0, 0, 3'd0, 2'b00, 2'b00, 2'b00, 0);
    chk("cm_lru5", 32'(dut.u_lru.bits_q[5]), 1);

    // Prime lru[3]=1, then dirty miss: victim way 1 is valid and dirty
    drive(1, 0, 3'd3, 2'b01, 2'b11, 2'b10, 0);
    tick();
    drive(0, 1, 3'd3, 2'b00, 2'b11, 2'b10, 0);
    @(negedge clk);
    chk("dm_pwr0", 32'(pmem_write), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("dm_pwr", 32'(pmem_write), 1);
      chk("dm_src", 32'(sourcemux_sel), 32'(sourcemux::cache));
      chk("dm_way", 32'(way_sel), 1);
    end
    tick(); pmem_resp = 1'b1;
    @(negedge clk);
    chk("dm_wbend", 32'(pmem_write), 1);
    tick(); pmem_resp = 1'b0;
    @(negedge clk);
    chk("dm_prd",  32'(pmem_read), 1);
    chk("dm_apwr", 32'(pmem_write), 0);
    chk("dm_asrc", 32'(sourcemux_sel), 32'(sourcemux::memory));
    chk("dm_away", 32'(way_sel), 1);
    tick(); pmem_resp = 1'b1;
    @(negedge clk);
    chk("dm_ftag", 32'(load_tag), 32'b10);
    chk("dm_fld",  32'(load_data), 32'b10);
    tick(); drive(0, 1, 3'd3, 2'b10, 2'b11, 2'b00, 0);
    @(negedge clk);
    chk("dm_hresp", 32'(mem_resp), 1);
    chk("dm_hld",   32'(load_data), 32'b10);
    chk("dm_hsd",   32'(set_dirty), 32'b10);
    tick(); drive(0, 0, 3'd0, 2'b00, 2'b00, 2'b00, 0);
    chk("dm_lru3", 32'(dut.u_lru.bits_q[3]), 0);

    // Both hit bits set: way 0 wins
    drive(1, 0, 3'd4, 2'b11, 2'b11, 2'b00, 0);
    @(negedge clk);
    chk("hh_way", 32'(way_sel), 0);
    tick(); drive(0, 0, 3'd0, 2'b00, 2'b00, 2'b00, 0);
    chk("hh_lru4", 32'(dut.u_lru.bits_q[4]), 1);

    // Read and write together on a hit: write path
    drive(1, 1, 3'd1, 2'b01, 2'b11, 2'b00, 0);
    @(negedge clk);
    chk("rw_resp", 32'(mem_resp), 1);
    chk("rw_ld",   32'(load_data), 32'b01);
    chk("rw_sd",   32'(set_dirty), 32'b01);
    tick(); drive(0, 0, 3'd0, 2'b00, 2'b00, 2'b00, 0);

    // Reset in the middle of ALLOCATE
    drive(1, 0, 3'd6, 2'b00, 2'b00, 2'b00, 0);
    tick(); drive(0, 0, 3'd6, 2'b00, 2'b00, 2'b00, 0);
    @(negedge clk);
    chk("ra_prd", 32'(pmem_read), 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("ra_prd0", 32'(pmem_read), 0);
    chk("ra_resp", 32'(mem_resp), 0);
    chk("ra_lru",  32'(dut.u_lru.bits_q), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
